// File: rtl/mci_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcodes, mux/ALU select encodings and the packed control word.
package mci_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mci_ctrl_decode.sv
// Combinational control-word decoder: maps the current state (plus the
// mem_ready qualifier used in FETCH) to the datapath control signals.
// The JUMP state outputs exist only when MCI_JUMP_EN is defined.
module mci_ctrl_decode
   import mci_pkg::*;
(
   input  logic [3:0]        state_i,
   input  logic              mem_ready_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t c;

   // Moore control word per state; FETCH adds the mem_ready qualifier.
   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      c = '0;
      unique case (state_e'(state_i))
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_OP_ADD;
            c.pc_source = PCSRC_ALU;
            c.ir_write  = mem_ready_i;
            c.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH;
            c.alu_op    = ALU_OP_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_OP_ADD;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_OP_FUNCT;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_OP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
`ifdef MCI_JUMP_EN
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
`endif
         default: c = '0;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/mci_control_fsm.sv
// Multicycle MIPS control unit top: state register, next-state logic,
// completion/illegal pulses and the retired-instruction counter.
// Optional jump support is enabled by defining MCI_JUMP_EN.
module mci_control_fsm
   import mci_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_raw;
   logic               illegal_raw;
   logic [CTRL_W-1:0]  ctrl_bits;
   ctrl_t              ctrl;

   mci_ctrl_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl_bits)
   );

   // Next state plus the one-cycle completion and illegal-opcode pulses.
   always_comb begin
      state_d     = state_q;
      done_raw    = 1'b0;
      illegal_raw = 1'b0;
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MCI_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  state_d     = S_FETCH;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB: begin
            state_d  = S_FETCH;
            done_raw = 1'b1;
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d  = S_FETCH;
               done_raw = 1'b1;
            end
         end
         S_EXEC:     state_d = S_ALU_WB;
         S_ALU_WB: begin
            state_d  = S_FETCH;
            done_raw = 1'b1;
         end
         S_BRANCH: begin
            state_d  = S_FETCH;
            done_raw = 1'b1;
         end
`ifdef MCI_JUMP_EN
         S_JUMP: begin
            state_d  = S_FETCH;
            done_raw = 1'b1;
         end
`endif
         // Unused encodings (and JUMP when jumps are disabled) recover to FETCH.
         default:    state_d = S_FETCH;
      endcase
   end

   // Retired-instruction counter, wrapping naturally at 2^CNT_W.
   always_comb begin
      cnt_d = done_raw ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // State and counter registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces all controls quiet, including FETCH's memory read.
   assign ctrl = reset ? '0 : ctrl_t'(ctrl_bits);

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign state         = state_q;
   assign instr_done    = ~reset & done_raw;
   assign illegal_op    = ~reset & illegal_raw;
   assign instr_count   = cnt_q;

endmodule

// File: tb/tb_mci_control_fsm.sv
// Scoreboard bench for mci_control_fsm. A generator expands each instruction
// into its expected cycle-by-cycle behaviour; a driver applies the inputs and
// queues the expectation; a monitor compares on every falling edge.
module tb_mci_control_fsm;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic [3:0]       state;
   logic             instr_done, illegal_op;
   logic [CNT_W-1:0] instr_count;

   mci_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state         (state),
      .instr_done    (instr_done),
      .illegal_op    (illegal_op),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   // Observed vector: [21:18] state, then one bit per control, 2-bit fields,
   // then instr_done and illegal_op.
   wire [21:0] act_vec = {state, pc_write, pc_write_cond, i_or_d, mem_read,
                          mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                          alu_src_a, alu_src_b, alu_op, pc_source,
                          instr_done, illegal_op};

   localparam logic [21:0] PW   = 22'd1 << 17;
   localparam logic [21:0] PWC  = 22'd1 << 16;
   localparam logic [21:0] IOD  = 22'd1 << 15;
   localparam logic [21:0] MRD  = 22'd1 << 14;
   localparam logic [21:0] MWR  = 22'd1 << 13;
   localparam logic [21:0] IRW  = 22'd1 << 12;
   localparam logic [21:0] M2R  = 22'd1 << 11;
   localparam logic [21:0] RDST = 22'd1 << 10;
   localparam logic [21:0] RW   = 22'd1 << 9;
   localparam logic [21:0] ASA  = 22'd1 << 8;
   localparam logic [21:0] DONE = 22'd1 << 1;
   localparam logic [21:0] ILL  = 22'd1;

   function automatic logic [21:0] st_f(input int s);   return 22'(s) << 18; endfunction
   function automatic logic [21:0] asb_f(input int v);  return 22'(v) << 6;  endfunction
   function automatic logic [21:0] aop_f(input int v);  return 22'(v) << 4;  endfunction
   function automatic logic [21:0] psrc_f(input int v); return 22'(v) << 2;  endfunction

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [21:0] vec;
      logic [31:0] cnt;
   } item_t;

   item_t       plan_q[$];
   item_t       exp_q[$];
   item_t       mon_it;
   logic [31:0] model_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] op);
      logic jmp;
`ifdef MCI_JUMP_EN
      jmp = 1'b1;
`else
      jmp = 1'b0;
`endif
      return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (jmp && op == 6'b000010);
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // One expected cycle; the counter advances after any completing cycle.
   task automatic push(input logic [5:0] op, input logic mr, input logic [21:0] v);
      item_t it;
      it.op  = op;
      it.mr  = mr;
      it.vec = v;
      it.cnt = model_cnt;
      plan_q.push_back(it);
      if (v[1]) model_cnt = model_cnt + 1;
   endtask

   // Expands one instruction: wf fetch stall cycles, wm memory stall cycles.
   task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
      logic [21:0] fv;
      fv = st_f(0) | MRD | asb_f(1);
      for (int i = 0; i < wf; i++) push(op, 1'b0, fv);
      push(op, 1'b1, fv | PW | IRW);
      if (!is_legal(op)) begin
         push(op, rnd1(), st_f(1) | asb_f(3) | ILL);
         return;
      end
      push(op, rnd1(), st_f(1) | asb_f(3));
      case (op)
         6'b100011: begin
            push(op, rnd1(), st_f(2) | ASA | asb_f(2));
            for (int i = 0; i < wm; i++) push(op, 1'b0, st_f(3) | MRD | IOD);
            push(op, 1'b1, st_f(3) | MRD | IOD);
            push(op, rnd1(), st_f(4) | RW | M2R | DONE);
         end
         6'b101011: begin
            push(op, rnd1(), st_f(2) | ASA | asb_f(2));
            for (int i = 0; i < wm; i++) push(op, 1'b0, st_f(5) | MWR | IOD);
            push(op, 1'b1, st_f(5) | MWR | IOD | DONE);
         end
         6'b000000: begin
            push(op, rnd1(), st_f(6) | ASA | aop_f(2));
            push(op, rnd1(), st_f(7) | RW | RDST | DONE);
         end
         6'b000100: push(op, rnd1(), st_f(8) | ASA | aop_f(1) | PWC | psrc_f(1) | DONE);
         default:   push(op, rnd1(), st_f(9) | PW | psrc_f(2) | DONE);
      endcase
   endtask

   // Driver: applies each planned cycle just after the rising edge.
   task automatic run_plan();
      item_t it;
      while (plan_q.size() > 0) begin
         it        = plan_q.pop_front();
         opcode    = it.op;
         mem_ready = it.mr;
         exp_q.push_back(it);
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compares the presented outputs against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_it = exp_q.pop_front();
         check("ctl", 64'(act_vec), 64'(mon_it.vec));
         check("count", 64'(instr_count), 64'(mon_it.cnt));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0] op;
      int         r;
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      repeat (2) begin
         @(negedge clk);
         check("reset_ctl", 64'(act_vec), 64'd0);
         check("reset_cnt", 64'(instr_count), 64'd0);
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      model_cnt = 0;

      gen_instr(6'b000000, 0, 0);
      gen_instr(6'b100011, 0, 3);
      gen_instr(6'b101011, 0, 0);
      gen_instr(6'b000100, 0, 0);
      gen_instr(6'b111111, 0, 0);
      gen_instr(6'b000010, 0, 0);
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1:    op = 6'b000000;
            2, 3:    op = 6'b100011;
            4, 5:    op = 6'b101011;
            6, 7:    op = 6'b000100;
            8:       op = 6'b000010;
            default: begin
               op = 6'($urandom);
               while (is_legal(op) || op == 6'b000010) op = 6'($urandom);
            end
         endcase
         gen_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      run_plan();

      // Park a load in MEM_RD, then hit it with an asynchronous reset.
      push(6'b100011, 1'b1, st_f(0) | MRD | asb_f(1) | PW | IRW);
      push(6'b100011, 1'b1, st_f(1) | asb_f(3));
      push(6'b100011, 1'b1, st_f(2) | ASA | asb_f(2));
      repeat (3) push(6'b100011, 1'b0, st_f(3) | MRD | IOD);
      run_plan();
      #2;
      reset = 1'b1;
      #1;
      check("abort_ctl", 64'(act_vec), 64'd0);
      check("abort_cnt", 64'(instr_count), 64'd0);
      @(posedge clk);
      #1;
      check("abort_hold", 64'(act_vec), 64'd0);
      reset     = 1'b0;
      model_cnt = 0;
      gen_instr(6'b000000, 0, 0);
      push(6'b000000, 1'b0, st_f(0) | MRD | asb_f(1));
      run_plan();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
